filter_spad_mc: RTL

Multi-channel filter scratchpad for the PE: holds NUM_CH independent filter rows in one shared memory. Each row is filled sequentially, then streamed out with automatic address generation and wrap-around for a configurable number of reuse passes. After the final pass the row is released for refill. It sits between the filter-load network and the MAC datapath, and lets the PE prefetch the next filter row while the current one is still being consumed.

---
 rtl/filter_spad_mc_if.sv | 49 ++++
 rtl/filter_spad_mc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/filter_spad_mc_if.sv
// Filter scratchpad bus: configuration, write (fill) and read (stream) channels.
//   master : drives cfg_*, wr_valid/wr_ch/wr_data, rd_en/rd_ch
//   slave  : drives wr_ready, rd_ready, rd_valid/rd_data/rd_last/rd_done, full, empty
interface filter_spad_mc_if #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned MEM_DEPTH   = 224,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned REUSE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH  = $clog2(MEM_DEPTH),
    parameter int unsigned CH_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                   cfg_load;
    logic [ADDR_WIDTH:0]    cfg_depth;
    logic [REUSE_WIDTH-1:0] cfg_reuse;

    logic                   wr_valid;
    logic [CH_WIDTH-1:0]    wr_ch;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   wr_ready;

    logic                   rd_en;
    logic [CH_WIDTH-1:0]    rd_ch;
    logic                   rd_ready;
    logic                   rd_valid;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_last;
    logic                   rd_done;

    logic [NUM_CH-1:0]      full;
    logic [NUM_CH-1:0]      empty;

    modport master (
        output cfg_load, cfg_depth, cfg_reuse,
        output wr_valid, wr_ch, wr_data,
        input  wr_ready,
        output rd_en, rd_ch,
        input  rd_ready, rd_valid, rd_data, rd_last, rd_done,
        input  full, empty
    );

    modport slave (
        input  cfg_load, cfg_depth, cfg_reuse,
        input  wr_valid, wr_ch, wr_data,
        output wr_ready,
        input  rd_en, rd_ch,
        output rd_ready, rd_valid, rd_data, rd_last, rd_done,
        output full, empty
    );
endinterface

// File: rtl/filter_spad_mc.sv
// Multi-channel filter scratchpad. NUM_CH filter rows share one memory; each row is
// filled sequentially, then streamed out cfg_reuse times with wrap-around, then released.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : filter_spad_mc_if.slave (config, fill port, stream port, per-channel status)
module filter_spad_mc #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned MEM_DEPTH   = 224,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned REUSE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH  = $clog2(MEM_DEPTH),
    parameter int unsigned CH_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    filter_spad_mc_if.slave  bus
);
    localparam int unsigned MEM_WORDS = NUM_CH * MEM_DEPTH;
    localparam int unsigned MEM_AW    = $clog2(MEM_WORDS);

    typedef enum logic {StFill, StRead} ch_state_e;

    logic [DATA_WIDTH-1:0]  r_mem [MEM_WORDS];

    ch_state_e              r_state    [NUM_CH];
    ch_state_e              w_state_nxt[NUM_CH];
    logic [ADDR_WIDTH:0]    r_wptr     [NUM_CH];
    logic [ADDR_WIDTH:0]    w_wptr_nxt [NUM_CH];
    logic [ADDR_WIDTH-1:0]  r_rptr     [NUM_CH];
    logic [ADDR_WIDTH-1:0]  w_rptr_nxt [NUM_CH];
    logic [REUSE_WIDTH-1:0] r_pass     [NUM_CH];
    logic [REUSE_WIDTH-1:0] w_pass_nxt [NUM_CH];

    logic [ADDR_WIDTH:0]    r_depth;
    logic [REUSE_WIDTH-1:0] r_reuse;

    logic                   r_rd_valid;
    logic [DATA_WIDTH-1:0]  r_rd_data;
    logic                   r_rd_last;
    logic                   r_rd_done;

    logic                   w_wr_ch_ok, w_rd_ch_ok;
    logic                   w_wr_ready, w_rd_ready;
    logic                   w_wr_fire, w_rd_fire;
    logic                   w_rd_at_end, w_rd_final;
    logic [MEM_AW-1:0]      w_wr_addr, w_rd_addr;

    // Out-of-range channel indices (non-power-of-2 NUM_CH) never get a ready.
    assign w_wr_ch_ok = (32'(bus.wr_ch) < NUM_CH);
    assign w_rd_ch_ok = (32'(bus.rd_ch) < NUM_CH);

    assign w_wr_ready = !bus.cfg_load && w_wr_ch_ok && (r_state[bus.wr_ch] == StFill);
    assign w_rd_ready = !bus.cfg_load && w_rd_ch_ok && (r_state[bus.rd_ch] == StRead);
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;
    assign w_rd_fire  = bus.rd_en && w_rd_ready;

    assign w_rd_at_end = ({1'b0, r_rptr[bus.rd_ch]} == (r_depth - 1'b1));
    assign w_rd_final  = w_rd_at_end && (r_pass[bus.rd_ch] == (r_reuse - 1'b1));

    assign w_wr_addr = MEM_AW'(bus.wr_ch) * MEM_AW'(MEM_DEPTH) + MEM_AW'(r_wptr[bus.wr_ch]);
    assign w_rd_addr = MEM_AW'(bus.rd_ch) * MEM_AW'(MEM_DEPTH) + MEM_AW'(r_rptr[bus.rd_ch]);

    // Per-channel FILL/READ next-state. A channel is never written and read in the same
    // cycle since the two ports require opposite states.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_nxt[c] = r_state[c];
            w_wptr_nxt[c]  = r_wptr[c];
            w_rptr_nxt[c]  = r_rptr[c];
            w_pass_nxt[c]  = r_pass[c];
            if (bus.cfg_load) begin
                w_state_nxt[c] = StFill;
                w_wptr_nxt[c]  = '0;
                w_rptr_nxt[c]  = '0;
                w_pass_nxt[c]  = '0;
            end else begin
                if (w_wr_fire && (bus.wr_ch == CH_WIDTH'(c))) begin
                    w_wptr_nxt[c] = r_wptr[c] + 1'b1;
                    if ((r_wptr[c] + 1'b1) == r_depth) begin
                        w_state_nxt[c] = StRead;
                        w_rptr_nxt[c]  = '0;
                        w_pass_nxt[c]  = '0;
                    end
                end
                if (w_rd_fire && (bus.rd_ch == CH_WIDTH'(c))) begin
                    if (w_rd_at_end) begin
                        w_rptr_nxt[c] = '0;
                        if (w_rd_final) begin
                            w_state_nxt[c] = StFill;
                            w_wptr_nxt[c]  = '0;
                            w_pass_nxt[c]  = '0;
                        end else begin
                            w_pass_nxt[c] = r_pass[c] + 1'b1;
                        end
                    end else begin
                        w_rptr_nxt[c] = r_rptr[c] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= StFill;
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_pass[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_wptr[c]  <= w_wptr_nxt[c];
                r_rptr[c]  <= w_rptr_nxt[c];
                r_pass[c]  <= w_pass_nxt[c];
            end
        end
    end

    // Out-of-range depth and zero reuse are clamped at latch time so the datapath
    // never has to special-case them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_depth <= (ADDR_WIDTH+1)'(MEM_DEPTH);
            r_reuse <= REUSE_WIDTH'(1);
        end else if (bus.cfg_load) begin
            if ((bus.cfg_depth == '0) || (32'(bus.cfg_depth) > MEM_DEPTH)) begin
                r_depth <= (ADDR_WIDTH+1)'(MEM_DEPTH);
            end else begin
                r_depth <= bus.cfg_depth;
            end
            r_reuse <= (bus.cfg_reuse == '0) ? REUSE_WIDTH'(1) : bus.cfg_reuse;
        end
    end

    // Read data holds its last value when no read is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
            r_rd_done  <= 1'b0;
        end else if (w_rd_fire) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= r_mem[w_rd_addr];
            r_rd_last  <= w_rd_at_end;
            r_rd_done  <= w_rd_final;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_done  <= 1'b0;
        end
    end

    // Storage is not reset; contents go stale on cfg_load or release.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        bus.full  = '0;
        bus.empty = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.full[c]  = (r_state[c] == StRead);
            bus.empty[c] = (r_state[c] == StFill) && (r_wptr[c] == '0);
        end
    end

    assign bus.wr_ready = w_wr_ready;
    assign bus.rd_ready = w_rd_ready;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_last  = r_rd_last;
    assign bus.rd_done  = r_rd_done;
endmodule
